ahb3lite_interconnect_slave_arbiter: RTL and testbench
======================================================

# ahb3lite_interconnect_slave_arbiter

Per-slave-port arbiter for the AHB3-Lite multi-layer switch. One instance sits in front of each slave port and decides which master port owns that slave. It collects the request, priority and `can_switch` signals from every master port. It returns a registered one-hot `master_granted` vector plus a binary owner index that drives the slave-port address/data muxes. Arbitration is priority-based with round-robin among equal priorities. Ownership changes only at AHB-safe points: when the owner may switch and the slave is ready.

## Interface
- `MASTERS`, default 3: number of master ports arbitrated (≥1).
- `MASTER_BITS`, default `max(1,$clog2(MASTERS))`: owner index width (localparam).

Ports:
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HCLK` in 1: clock, rising edge.
- `mst_req` in `MASTERS`: bit m = master port m selects this slave (its `slvHSEL` bit for this slave).
- `mst_priority` in `MASTERS`×3: per-master priority; larger value wins.
- `mst_can_switch` in `MASTERS`: bit m = master m's current transfer permits hand-over on next cycle.
- `slv_HREADY` in 1: HREADYOUT of the attached slave.
- `master_granted` out `MASTERS`: registered one-hot ownership vector, fanned back to master ports.
- `owner_sel` out `MASTER_BITS`: binary index of the set `master_granted` bit.
- `grant_changed` out 1: registered one-cycle pulse, high in the first cycle of a new owner.

## Operation
- **Owner register.**
  - Holds exactly one set bit at all times (parking arbiter).
  - `owner_sel` always encodes that bit.
- **Switch window.** `switch_ok = slv_HREADY & (~mst_req[owner] | mst_can_switch[owner])`.
  - Outside the window, `master_granted`, `owner_sel` and the RR pointer hold.
  - `grant_changed` is 0 in any cycle following a held edge.
- **Candidate set** (evaluated only when `switch_ok` = 1):
  - `max_pri` = highest `mst_priority` among requesting masters.
  - Candidates = requesters with priority == `max_pri`.
- **Selection.**
  - Scan candidates starting at index `(rr_ptr+1) mod MASTERS`, wrapping upward.
  - The first candidate found becomes the next owner.
  - The current owner is a valid candidate. It keeps the grant only if no other candidate precedes it in the scan.
- **No requesters.** When `switch_ok` = 1 and `mst_req` = 0, the owner holds (parks). No pulse, pointer unchanged.
- **RR pointer update.**
  - `rr_ptr` ← new owner index whenever a selection is made with ≥1 requester, including a re-grant to the same master.
  - The pointer is internal state and not exported.
- **grant_changed.** Registered as `switch_ok & |mst_req & (next_owner != owner)`.
- **Priority inversion.** There is no pre-emption. A higher-priority request waits until the owner's `mst_can_switch` is 1 or the owner drops its request, and `slv_HREADY` = 1.
- **Locked sequences.** Master ports deassert `can_switch` while HMASTLOCK is set. The arbiter needs no separate lock input.

## Timing
- **Reset values** (asynchronous, immediate on HRESETn low):
  - `master_granted` = `{{MASTERS-1{0}},1}` (master 0 parked).
  - `owner_sel` = 0.
  - `grant_changed` = 0.
  - `rr_ptr` = `MASTERS-1`, so master 0 wins the first tie.
- **Latency.** Inputs sampled at edge N produce the new `master_granted`, `owner_sel` and `grant_changed` in cycle N+1. There is no combinational path from any input to any output.
- **HREADY stall.** While `slv_HREADY` = 0, outputs are frozen regardless of `mst_req` or `mst_can_switch` changes.
- **Simultaneous events.**
  - The owner drops its request in the same cycle another master raises one: the other master is granted at the next edge, provided `slv_HREADY` = 1.
  - Equal-priority requests arriving together: round-robin order decides.
- **Reset mid-transfer.** Grant returns to master 0 immediately and `grant_changed` clears. There is no pending-state recovery.
- **Single-master build** (`MASTERS`=1): `master_granted` is constantly 1, `owner_sel` = 0, `grant_changed` = 0.

## Test plan
- **Reset and single requester.** Release reset with `mst_req`=0 → `master_granted`=001, `owner_sel`=0, `grant_changed`=0. Then `mst_req`=100, `can_switch[0]`=1, `slv_HREADY`=1 → next cycle `master_granted`=100, `owner_sel`=2, `grant_changed` pulses exactly one cycle.
- **Priority.** Owner 0 with `can_switch`=1; `mst_req`=111, priorities {m0=1, m1=5, m2=3} → grant goes to m1. Keep all requests and can_switch asserted for 2 more cycles → m1 retains the grant with no further pulse.
- **Round-robin.** All three request at equal priority 2, all can_switch=1, HREADY=1 continuously → grant sequence 001→010→100→001 on successive cycles, with `grant_changed` high every cycle.
- **Lock hold.** Owner m1 with `can_switch[1]`=0 for 5 cycles while m2 requests at priority 7 → grant stays 010 for all 5 cycles. Assert `can_switch[1]`=1 → `master_granted`=100 the cycle after.
- **HREADY stall.** A switch condition is met but `slv_HREADY`=0 for 3 cycles → no change. HREADY returns to 1 → switch completes one cycle later.
- **Parking and async reset.** Drop all requests → owner holds its last value. Assert HRESETn low mid-cycle while owner=2 → `master_granted`=001 before the next clock edge.

Source files
------------

// File: rtl/ahb3lite_interconnect_slave_arbiter_if.sv
// Arbitration signals between the master ports and one slave-port arbiter.
// The master side drives requests and slave readiness; the slave side returns the grant.
interface ahb3lite_interconnect_slave_arbiter_if #(
    parameter int MASTERS = 3
);
    localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0]        mst_req;
    logic [MASTERS-1:0][2:0]   mst_priority;
    logic [MASTERS-1:0]        mst_can_switch;
    logic                      slv_HREADY;
    logic [MASTERS-1:0]        master_granted;
    logic [MASTER_BITS-1:0]    owner_sel;
    logic                      grant_changed;

    modport master (
        output mst_req, mst_priority, mst_can_switch, slv_HREADY,
        input  master_granted, owner_sel, grant_changed
    );

    modport slave (
        input  mst_req, mst_priority, mst_can_switch, slv_HREADY,
        output master_granted, owner_sel, grant_changed
    );
endinterface

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port parking arbiter: highest priority wins, round-robin among equals,
// ownership moves only when the slave is ready and the current owner allows it.
module ahb3lite_interconnect_slave_arbiter #(
    parameter int MASTERS = 3
) (
    input logic HRESETn,
    input logic HCLK,
    ahb3lite_interconnect_slave_arbiter_if.slave bus
);
    localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int unsigned NM = MASTERS;

    logic [MASTER_BITS-1:0] owner;
    logic [MASTER_BITS-1:0] rr_ptr;
    logic [MASTER_BITS-1:0] next_owner;
    logic [MASTERS-1:0]     next_granted;
    logic [2:0]             max_pri;
    logic                   switch_ok;
    logic                   take;
    logic                   found;
    logic [MASTER_BITS-1:0] idx;

    always_comb begin
        switch_ok = bus.slv_HREADY & (~bus.mst_req[owner] | bus.mst_can_switch[owner]);
        take      = switch_ok & (|bus.mst_req);

        max_pri = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (bus.mst_req[MASTER_BITS'(i)] && bus.mst_priority[MASTER_BITS'(i)] > max_pri)
                max_pri = bus.mst_priority[MASTER_BITS'(i)];
        end

        // Scan upward from the slot after the last winner; the owner only keeps
        // the grant if no other top-priority requester comes first.
        next_owner = owner;
        found      = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            idx = MASTER_BITS'((32'(rr_ptr) + k) % NM);
            if (!found && bus.mst_req[idx] && bus.mst_priority[idx] == max_pri) begin
                found      = 1'b1;
                next_owner = idx;
            end
        end

        next_granted             = '0;
        next_granted[next_owner] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner              <= '0;
            rr_ptr             <= MASTER_BITS'(NM - 1);
            bus.master_granted <= MASTERS'(1);
            bus.grant_changed  <= 1'b0;
        end else if (take) begin
            owner              <= next_owner;
            rr_ptr             <= next_owner;
            bus.master_granted <= next_granted;
            bus.grant_changed  <= (next_owner != owner);
        end else begin
            bus.grant_changed  <= 1'b0;
        end
    end

    assign bus.owner_sel = owner;
endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Directed scenarios plus randomized traffic, all checked against a
// queue/distance based reference of the arbitration rules.
module tb_ahb3lite_interconnect_slave_arbiter;
    localparam int M = 3;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int   m_owner;
    int   m_rr;
    bit   m_chg;

    ahb3lite_interconnect_slave_arbiter_if #(.MASTERS(M)) bus ();

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HRESETn (HRESETn),
        .HCLK    (HCLK),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [5:0] expv();
        logic [2:0] g;
        g = 3'(1 << m_owner);
        return {g, 2'(m_owner), m_chg};
    endfunction

    function automatic logic [5:0] actv();
        return {bus.master_granted, bus.owner_sel, bus.grant_changed};
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_rr    = M - 1;
        m_chg   = 0;
    endtask

    // Evaluates the arbitration rules on the inputs present just before the edge.
    task automatic clk();
        int       maxp;
        int       best;
        int       bestd;
        int       d;
        int       cands[$];
        m_chg = 0;
        if (bus.slv_HREADY && (!bus.mst_req[m_owner] || bus.mst_can_switch[m_owner]) && bus.mst_req != 0) begin
            maxp = -1;
            for (int i = 0; i < M; i++)
                if (bus.mst_req[i] && int'(bus.mst_priority[i]) > maxp) maxp = int'(bus.mst_priority[i]);
            for (int i = 0; i < M; i++)
                if (bus.mst_req[i] && int'(bus.mst_priority[i]) == maxp) cands.push_back(i);
            best = cands[0];
            bestd = M;
            foreach (cands[j]) begin
                d = (cands[j] - m_rr - 1 + 2 * M) % M;
                if (d < bestd) begin bestd = d; best = cands[j]; end
            end
            m_chg   = (best != m_owner);
            m_owner = best;
            m_rr    = best;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_in(input logic [2:0] req, input logic [8:0] pri,
                          input logic [2:0] cs, input logic rdy);
        bus.mst_req        = req;
        bus.mst_priority   = pri;
        bus.mst_can_switch = cs;
        bus.slv_HREADY     = rdy;
    endtask

    task automatic test_reset();
        set_in(3'b000, '0, 3'b111, 1'b1);
        HRESETn = 1'b0;
        model_reset();
        #12;
        n_vec++;
        if (actv() !== 6'b001_00_0) begin
            n_err++; $display("FAIL reset: got %b want %b", actv(), 6'b001_00_0);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        clk();
        n_vec++;
        if (actv() !== 6'b001_00_0) begin
            n_err++; $display("FAIL reset_idle: got %b want %b", actv(), 6'b001_00_0);
        end
    endtask

    task automatic test_single();
        set_in(3'b100, '0, 3'b111, 1'b1);
        clk();
        n_vec++;
        if (actv() !== 6'b100_10_1 || expv() !== 6'b100_10_1) begin
            n_err++; $display("FAIL single_grant: got %b want %b", actv(), 6'b100_10_1);
        end
        clk();
        n_vec++;
        if (actv() !== 6'b100_10_0) begin
            n_err++; $display("FAIL single_pulse_once: got %b want %b", actv(), 6'b100_10_0);
        end
    endtask

    task automatic test_priority();
        set_in(3'b001, '0, 3'b111, 1'b1);
        clk();
        set_in(3'b111, {3'd3, 3'd5, 3'd1}, 3'b111, 1'b1);
        clk();
        n_vec++;
        if (actv() !== 6'b010_01_1) begin
            n_err++; $display("FAIL priority_win: got %b want %b", actv(), 6'b010_01_1);
        end
        for (int c = 0; c < 2; c++) begin
            clk();
            n_vec++;
            if (actv() !== 6'b010_01_0) begin
                n_err++; $display("FAIL priority_hold%0d: got %b want %b", c, actv(), 6'b010_01_0);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] seq [4];
        seq[0] = 6'b010_01_1; seq[1] = 6'b100_10_1; seq[2] = 6'b001_00_1; seq[3] = 6'b010_01_1;
        set_in(3'b001, '0, 3'b111, 1'b1);
        clk();
        set_in(3'b111, {3'd2, 3'd2, 3'd2}, 3'b111, 1'b1);
        for (int c = 0; c < 4; c++) begin
            clk();
            n_vec++;
            if (actv() !== seq[c] || expv() !== seq[c]) begin
                n_err++; $display("FAIL rr_step%0d: got %b want %b", c, actv(), seq[c]);
            end
        end
    endtask

    task automatic test_lock();
        set_in(3'b010, '0, 3'b111, 1'b1);
        clk();
        set_in(3'b110, {3'd7, 3'd0, 3'd0}, 3'b101, 1'b1);
        for (int c = 0; c < 5; c++) begin
            clk();
            n_vec++;
            if (actv() !== 6'b010_01_0) begin
                n_err++; $display("FAIL lock_hold%0d: got %b want %b", c, actv(), 6'b010_01_0);
            end
        end
        bus.mst_can_switch = 3'b111;
        clk();
        n_vec++;
        if (actv() !== 6'b100_10_1) begin
            n_err++; $display("FAIL lock_release: got %b want %b", actv(), 6'b100_10_1);
        end
    endtask

    task automatic test_hready_stall();
        set_in(3'b011, {3'd4, 3'd4, 3'd4}, 3'b111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            clk();
            n_vec++;
            if (actv() !== 6'b100_10_0) begin
                n_err++; $display("FAIL stall%0d: got %b want %b", c, actv(), 6'b100_10_0);
            end
        end
        bus.slv_HREADY = 1'b1;
        clk();
        n_vec++;
        if (actv() !== 6'b001_00_1 || expv() !== 6'b001_00_1) begin
            n_err++; $display("FAIL stall_release: got %b want %b", actv(), 6'b001_00_1);
        end
    endtask

    task automatic test_park_async_reset();
        set_in(3'b100, '0, 3'b111, 1'b1);
        clk();
        set_in(3'b000, '0, 3'b111, 1'b1);
        for (int c = 0; c < 2; c++) begin
            clk();
            n_vec++;
            if (actv() !== 6'b100_10_0) begin
                n_err++; $display("FAIL park%0d: got %b want %b", c, actv(), 6'b100_10_0);
            end
        end
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (actv() !== 6'b001_00_0) begin
            n_err++; $display("FAIL async_reset: got %b want %b", actv(), 6'b001_00_0);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(3'($urandom), 9'($urandom) & {3{($urandom_range(0, 3) == 0) ? 3'b111 : 3'b001}},
                   3'($urandom), ($urandom_range(0, 4) != 0));
            clk();
            n_vec++;
            if (actv() !== expv()) begin
                n_err++; $display("FAIL random%0d: got %b want %b", c, actv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_lock();
        test_hready_stall();
        test_park_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
